// File: rtl/r2sdf_bfly_stage_32b_if.sv
// Sample stream bundle for one R2SDF butterfly stage: the sample input with
// its drain request, and the butterfly output with its twiddle tag.
interface r2sdf_bfly_stage_32b_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_tw_en;
  logic [4:0]  out_tw_idx;

  modport master (
    output in_valid, in_data, flush,
    input  out_valid, out_data, out_tw_en, out_tw_idx
  );

  modport slave (
    input  in_valid, in_data, flush,
    output out_valid, out_data, out_tw_en, out_tw_idx
  );
endinterface

// File: rtl/r2sdf_bfly_stage_32b.sv
// Radix-2 single-path delay-feedback DIF butterfly stage. The first half of
// each block fills the delay line, and the second half emits sums while feeding
// differences back; those differences drain during the next block's first half.
module r2sdf_bfly_stage_32b #(
  parameter int N     = 64,
  parameter int DELAY = 32,
  parameter int SCALE = 1
) (
  input  logic clk,
  input  logic rst,
  r2sdf_bfly_stage_32b_if.slave bus
);
  localparam int              CW      = $clog2(2 * DELAY);
  localparam logic [CW-1:0]   J_LAST  = CW'(DELAY - 1);
  localparam logic [31:0]     TW_STEP = 32'(N / (2 * DELAY));

  logic [CW-1:0] cnt, cnt_nxt, j;
  logic          primed, primed_nxt;
  logic          phase, adv, flush_adv;
  logic [31:0]   dline [DELAY];
  logic [31:0]   pop, x, push, sum;
  logic [15:0]   sum_re, sum_im, dif_re, dif_im;
  logic [4:0]    tw_idx;

  logic          out_valid_q, out_tw_en_q;
  logic [31:0]   out_data_q;
  logic [4:0]    out_tw_idx_q;

  // Either keep the top 16 bits (halve) or the bottom 16 bits (wrap).
  function automatic logic [15:0] fold(input logic [16:0] v);
    return (SCALE != 0) ? v[16:1] : v[15:0];
  endfunction

  assign x     = bus.in_data;
  assign pop   = dline[DELAY-1];
  assign phase = cnt[CW-1];
  assign j     = cnt & J_LAST;

  // A drain step only happens while idle and a stored block is waiting.
  assign flush_adv = ~bus.in_valid & bus.flush & primed & ~phase;
  assign adv       = bus.in_valid | flush_adv;

  assign sum_re = fold({pop[31], pop[31:16]} + {x[31], x[31:16]});
  assign sum_im = fold({pop[15], pop[15:0]}  + {x[15], x[15:0]});
  assign dif_re = fold({pop[31], pop[31:16]} - {x[31], x[31:16]});
  assign dif_im = fold({pop[15], pop[15:0]}  - {x[15], x[15:0]});
  assign sum    = {sum_re, sum_im};

  assign push   = phase ? {dif_re, dif_im} : (bus.in_valid ? x : 32'h0);
  assign tw_idx = 5'(32'(j) * TW_STEP);

  always_comb begin
    cnt_nxt    = cnt;
    primed_nxt = primed;
    if (adv) begin
      if (flush_adv && j == J_LAST) begin
        cnt_nxt    = '0;
        primed_nxt = 1'b0;
      end else begin
        cnt_nxt = cnt + 1'b1;
        if (phase) primed_nxt = 1'b1;
      end
    end
  end

  // Delay line holds data only; stale contents are harmless while unprimed.
  always_ff @(posedge clk) begin
    if (adv) begin
      dline[0] <= push;
      for (int i = 1; i < DELAY; i++) dline[i] <= dline[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      primed       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_tw_en_q  <= 1'b0;
      out_tw_idx_q <= '0;
    end else begin
      cnt         <= cnt_nxt;
      primed      <= primed_nxt;
      out_valid_q <= adv & (phase | primed);
      if (adv && phase) begin
        out_data_q   <= sum;
        out_tw_en_q  <= 1'b0;
        out_tw_idx_q <= '0;
      end else if (adv && primed) begin
        out_data_q   <= pop;
        out_tw_en_q  <= 1'b1;
        out_tw_idx_q <= tw_idx;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_tw_en  = out_tw_en_q;
  assign bus.out_tw_idx = out_tw_idx_q;
endmodule

// File: tb/tb_r2sdf_bfly_stage_32b.sv
// Drives five stage configurations from one shared stream; a block-level
// model predicts each output cycle, and directed literals pin key results.
module tb_r2sdf_bfly_stage_32b;
  localparam int NI = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] in_data = '0;

  logic        o_v   [NI];
  logic [31:0] o_d   [NI];
  logic        o_en  [NI];
  logic [4:0]  o_idx [NI];

  int nvec = 0, nerr = 0, cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic int dly(input int k);
    case (k)
      0: return 1;
      1: return 2;
      2: return 1;
      3: return 32;
      default: return 4;
    endcase
  endfunction
  function automatic int nfft(input int k);
    return (k == 4) ? 64 : 2 * dly(k);
  endfunction
  function automatic int scl(input int k);
    return (k >= 2) ? 1 : 0;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    r2sdf_bfly_stage_32b_if bus ();
    assign bus.in_valid = in_valid;
    assign bus.in_data  = in_data;
    assign bus.flush    = flush;
    r2sdf_bfly_stage_32b #(.N(nfft(g)), .DELAY(dly(g)), .SCALE(scl(g))) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
    assign o_v[g]   = bus.out_valid;
    assign o_d[g]   = bus.out_data;
    assign o_en[g]  = bus.out_tw_en;
    assign o_idx[g] = bus.out_tw_idx;
  end

  // Block-level model: first half of a block stored in sa[], sums emitted in
  // the second half, differences kept in sd[] and emitted in the next first half.
  int          pos    [NI];
  bit          primed [NI];
  logic [31:0] sa     [NI][32];
  logic [31:0] sd     [NI][32];
  logic        ev     [NI];
  logic [31:0] ed     [NI];
  logic        een    [NI];
  logic [4:0]  eidx   [NI];

  function automatic logic [15:0] fold(input int v, input int sc);
    return (sc != 0) ? 16'(v >>> 1) : 16'(v);
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < NI; k++) begin
      int d, j, ar, ai, br, bi;
      d = dly(k);
      if (rst) begin
        pos[k] = 0; primed[k] = 1'b0;
        ev[k] = 1'b0; ed[k] = '0; een[k] = 1'b0; eidx[k] = '0;
      end else if (in_valid || (flush && primed[k] && pos[k] < d)) begin
        if (pos[k] < d) begin
          j = pos[k];
          ev[k] = primed[k];
          if (primed[k]) begin
            ed[k] = sd[k][j]; een[k] = 1'b1;
            eidx[k] = 5'(j * (nfft(k) / (2 * d)));
          end
          sa[k][j] = in_valid ? in_data : 32'h0;
          if (!in_valid && j == d - 1) begin
            pos[k] = 0; primed[k] = 1'b0;
          end else pos[k] = pos[k] + 1;
        end else begin
          j  = pos[k] - d;
          ar = $signed(sa[k][j][31:16]); ai = $signed(sa[k][j][15:0]);
          br = $signed(in_data[31:16]);  bi = $signed(in_data[15:0]);
          ed[k] = {fold(ar + br, scl(k)), fold(ai + bi, scl(k))};
          sd[k][j] = {fold(ar - br, scl(k)), fold(ai - bi, scl(k))};
          ev[k] = 1'b1; een[k] = 1'b0; eidx[k] = '0; primed[k] = 1'b1;
          pos[k] = (pos[k] == 2 * d - 1) ? 0 : pos[k] + 1;
        end
      end else ev[k] = 1'b0;
    end
  end

  typedef struct { logic [31:0] d; logic en; logic [4:0] idx; int cyc; } ent_t;
  ent_t lg [NI][$];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        nvec++;
        if (o_v[k] !== ev[k]) begin
          nerr++;
          $display("FAIL valid[%0d] cyc %0d: got %b want %b", k, cyc, o_v[k], ev[k]);
        end else if (ev[k]) begin
          nvec++;
          if ({o_d[k], o_en[k], o_idx[k]} !== {ed[k], een[k], eidx[k]}) begin
            nerr++;
            $display("FAIL out[%0d] cyc %0d: got %h/%b/%0d want %h/%b/%0d", k, cyc,
                     o_d[k], o_en[k], o_idx[k], ed[k], een[k], eidx[k]);
          end
        end
        if (o_v[k] === 1'b1) lg[k].push_back('{o_d[k], o_en[k], o_idx[k], cyc});
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic chk_ent(input string nm, input int k, input int i,
                         input logic [31:0] d, input logic en, input logic [4:0] idx);
    if (i < lg[k].size()) chk(nm, {lg[k][i].d, lg[k][i].en, lg[k][i].idx}, {d, en, idx});
    else begin
      nvec++; nerr++;
      $display("FAIL %s: got no output want %h/%b/%0d", nm, d, en, idx);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic f);
    in_valid = v; in_data = d; flush = f;
    @(posedge clk); #1;
  endtask

  task automatic do_rst();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++)
      chk("rst_state", {o_v[k], o_d[k], o_en[k], o_idx[k]}, 64'h0);
    for (int k = 0; k < NI; k++) lg[k].delete();
  endtask

  initial begin
    bit ok;
    // Smallest stage: one pair, one drain step, then unprimed again.
    do_rst();
    step(1, 32'h0064_0000, 0);
    step(1, 32'h0014_FFFC, 0);
    step(0, 32'h0, 1);
    step(0, 32'h0, 0); step(0, 32'h0, 0);
    chk("t1_count", lg[0].size(), 2);
    chk_ent("t1_sum", 0, 0, 32'h0078_FFFC, 1'b0, 5'd0);
    chk_ent("t1_dif", 0, 1, 32'h0050_0004, 1'b1, 5'd0);
    step(1, 32'h0005_0005, 0);
    step(0, 32'h0, 0); step(0, 32'h0, 0);
    chk("t1_unprimed", lg[0].size(), 2);

    // DELAY=2 with gaps and ignored flush requests.
    do_rst();
    step(0, 32'h0, 1);
    step(1, 32'h0001_0000, 1);
    step(0, 32'h0, 0);
    step(1, 32'h0002_0000, 0);
    step(0, 32'h0, 1);
    step(1, 32'h0003_0000, 1);
    step(1, 32'h0004_0000, 0);
    step(0, 32'h0, 1);
    step(0, 32'h0, 0);
    step(0, 32'h0, 1);
    step(0, 32'h0, 0); step(0, 32'h0, 0);
    chk("t2_count", lg[1].size(), 4);
    chk_ent("t2_s0", 1, 0, 32'h0004_0000, 1'b0, 5'd0);
    chk_ent("t2_s1", 1, 1, 32'h0006_0000, 1'b0, 5'd0);
    chk_ent("t2_d0", 1, 2, 32'hFFFE_0000, 1'b1, 5'd0);
    chk_ent("t2_d1", 1, 3, 32'hFFFE_0000, 1'b1, 5'd1);
    if (lg[1].size() == 4) begin
      chk("t2_gap_sums", lg[1][1].cyc - lg[1][0].cyc, 1);
      chk("t2_gap_difs", lg[1][3].cyc - lg[1][2].cyc, 2);
    end

    // Full-scale corner: scaled vs wrap-around.
    do_rst();
    step(1, 32'h7FFF_8000, 0);
    step(1, 32'h7FFF_8000, 0);
    step(0, 32'h0, 1);
    step(0, 32'h0, 0); step(0, 32'h0, 0);
    chk_ent("t3_sum_scaled", 2, 0, 32'h7FFF_8000, 1'b0, 5'd0);
    chk_ent("t3_dif_scaled", 2, 1, 32'h0000_0000, 1'b1, 5'd0);
    chk_ent("t3_sum_wrap",   0, 0, 32'hFFFE_0000, 1'b0, 5'd0);
    chk_ent("t3_dif_wrap",   0, 1, 32'h0000_0000, 1'b1, 5'd0);

    // Two back-to-back 64-sample impulse blocks on the DELAY=32 stage.
    do_rst();
    for (int i = 0; i < 128; i++) step(1, (i % 64 == 0) ? 32'h4000_0000 : 32'h0, 0);
    for (int i = 0; i < 32; i++) step(0, 32'h0, 1);
    step(0, 32'h0, 0); step(0, 32'h0, 0);
    chk("t4_count", lg[3].size(), 128);
    chk_ent("t4_b1_sum0", 3, 0, 32'h2000_0000, 1'b0, 5'd0);
    chk_ent("t4_b1_sum1", 3, 1, 32'h0000_0000, 1'b0, 5'd0);
    chk_ent("t4_b1_dif0", 3, 32, 32'h2000_0000, 1'b1, 5'd0);
    for (int i = 1; i < 32; i++) chk_ent("t4_b1_dif_idx", 3, 32 + i, 32'h0, 1'b1, 5'(i));
    chk_ent("t4_b2_sum0", 3, 64, 32'h2000_0000, 1'b0, 5'd0);
    chk_ent("t4_b2_dif0", 3, 96, 32'h2000_0000, 1'b1, 5'd0);
    ok = (lg[3].size() == 128);
    for (int i = 1; i < lg[3].size(); i++) if (lg[3][i].cyc != lg[3][0].cyc + i) ok = 1'b0;
    chk("t4_no_bubble", ok, 1'b1);

    // Reset mid phase B, then a fresh block.
    do_rst();
    for (int i = 0; i < 35; i++) step(1, {16'(1000 + i), 16'(7 * i)}, 0);
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h1234_5678; flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("t5_valid_after_rst", o_v[3], 1'b0);
    for (int k = 0; k < NI; k++) lg[k].delete();
    for (int i = 0; i < 64; i++) step(1, {16'(i + 1), 16'(3 * i)}, 0);
    for (int i = 0; i < 32; i++) step(0, 32'h0, 1);
    step(0, 32'h0, 0); step(0, 32'h0, 0);
    chk("t5_count", lg[3].size(), 64);
    chk_ent("t5_sum0", 3, 0, 32'h0011_0030, 1'b0, 5'd0);
    chk_ent("t5_dif0", 3, 32, 32'hFFF0_FFD0, 1'b1, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
